ds_iter: RTL
============

Name: ds_iter

Overview:
- Parametrised, sequential successor of the combinational divide-then-subtract datapath.
- Computes quotient = x / y, remainder = x % y, then difference = quotient - z.
- Uses an iterative restoring divider, one quotient bit per clock.
- Adds valid/ready handshakes, divide-by-zero detection, and an optional saturating subtract. It sits between the issue stage and writeback of the PE datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 2 to 64); iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- x  in  WIDTH  dividend (unsigned)
- y  in  WIDTH  divisor (unsigned)
- z  in  WIDTH  subtrahend (unsigned)
- sat_en  in  1  1 = difference clamps at 0 on borrow
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- quotient  out  WIDTH  x / y
- remainder  out  WIDTH  x % y
- difference  out  WIDTH  quotient - z (wrapped or saturated)
- borrow  out  1  quotient < z
- div_zero  out  1  y was 0

Behaviour:
- Reset (rst=0 at a clock edge):
  - state = IDLE; all outputs and internal registers = 0; out_valid = 0.
  - in_ready is forced 0 while rst=0.
  - Reset aborts any operation in progress; no partial result is ever presented.
- State machine: IDLE, DIV, SUB, DONE.
  - in_ready = 1 only in IDLE (and rst=1).
  - out_valid = 1 only in DONE.
- IDLE:
  - Acceptance occurs on an edge with in_valid=1 and in_ready=1 (edge E0).
  - On acceptance, x, y, z and sat_en are registered.
  - If y != 0: partial remainder = 0, count = 0, go to DIV.
  - If y == 0: quotient = all ones, remainder = x, div_zero = 1, go to SUB; DIV is skipped.
- DIV (one restoring step per edge):
  - Shift {rem, dividend} left by 1 and trial-subtract y from rem using a WIDTH+1-bit compare.
  - If rem >= y, subtract and set the quotient LSB to 1; otherwise the LSB is 0.
  - After WIDTH iterations (edge E_WIDTH), go to SUB.
  - Operand inputs are ignored while busy.
- SUB (single edge):
  - borrow = (quotient < z).
  - difference = (quotient - z) mod 2^WIDTH when sat_en = 0.
  - difference = 0 when sat_en = 1 and borrow = 1.
  - Go to DONE.
- Latency, accept edge to out_valid=1:
  - y != 0: WIDTH+2 edges.
  - y == 0: 2 edges.
- DONE:
  - quotient, remainder, difference, borrow and div_zero stay stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
  - Output registers keep their values after the handshake until the next result overwrites them; out_valid alone qualifies them.
  - div_zero and borrow are recomputed for every operation and never sticky.
- No overlap: a new accept can occur at the earliest one edge after the result handshake. Throughput is one result per WIDTH+3 cycles, minimum.
- in_valid and out_ready may be asserted permanently; the block self-paces.
- Corner cases:
  - x = 0 gives quotient 0, remainder 0.
  - y = 1 gives quotient x, remainder 0.
  - x < y gives quotient 0, remainder x.
  - The maximum operand (all ones) must not overflow the WIDTH+1-bit trial subtract.

Test Plan:
- WIDTH=32: x=100, y=7, z=4, sat_en=0 -> quotient=14, remainder=2, difference=10, borrow=0, div_zero=0; out_valid rises exactly 34 edges after the accept edge.
- WIDTH=32: x=10, y=5, z=5:
  - sat_en=0 -> difference=0xFFFFFFFD, borrow=1.
  - Repeat with sat_en=1 -> difference=0, borrow=1.
- WIDTH=32: x=55, y=0, z=1 -> quotient=0xFFFFFFFF, remainder=55, difference=0xFFFFFFFE, div_zero=1; out_valid 2 edges after accept. A following op x=9, y=3, z=0 -> quotient=3, remainder=0, div_zero=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs constant, in_ready=0, in_valid pulses ignored. Then raise out_ready -> IDLE on the next edge and in_ready=1.
- Reset mid-op: drive rst=0 for 1 edge at DIV iteration 10 -> out_valid=0, all outputs 0, state IDLE. The next op x=0xFFFFFFFF, y=1, z=0xFFFFFFFF -> quotient=0xFFFFFFFF, remainder=0, difference=0, borrow=0.
- WIDTH=8 instance: x=200, y=3, z=70, sat_en=1 -> quotient=66, remainder=2, difference=0, borrow=1; latency 10 edges.

Source files
------------

// File: rtl/ds_iter.sv
// Iterative divide-then-subtract: restoring divider (one quotient bit per clock)
// followed by a single-cycle wrapped/saturating subtract, with valid/ready on both sides.
module ds_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_z;
  logic             r_sat;
  logic             r_dz;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rmd;
  logic [WIDTH-1:0] r_dif;
  logic             r_bor;
  logic             r_dvz;

  // r_q starts as the dividend and fills with quotient bits from the LSB as
  // dividend bits shift out of its MSB into the partial remainder.
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic             w_borrow;
  logic [WIDTH-1:0] w_diff;

  // The trial value keeps one extra bit so an all-ones divisor cannot overflow;
  // when the subtract succeeds the result is below y and fits WIDTH bits.
  assign w_trial  = {r_rem, r_q[WIDTH-1]};
  assign w_ge     = (w_trial >= {1'b0, r_y});
  assign w_sub    = w_trial[WIDTH-1:0] - r_y;
  assign w_borrow = (r_q < r_z);
  assign w_diff   = (r_sat && w_borrow) ? '0 : (r_q - r_z);

  assign in_ready   = rst && (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign quotient   = r_quo;
  assign remainder  = r_rmd;
  assign difference = r_dif;
  assign borrow     = r_bor;
  assign div_zero   = r_dvz;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_q     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_sat   <= 1'b0;
      r_dz    <= 1'b0;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rmd   <= '0;
      r_dif   <= '0;
      r_bor   <= 1'b0;
      r_dvz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_y   <= y;
            r_z   <= z;
            r_sat <= sat_en;
            r_cnt <= '0;
            if (y == '0) begin
              r_q     <= '1;
              r_rem   <= x;
              r_dz    <= 1'b1;
              r_state <= S_SUB;
            end else begin
              r_q     <= x;
              r_rem   <= '0;
              r_dz    <= 1'b0;
              r_state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          r_rem <= w_ge ? w_sub : w_trial[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1))
            r_state <= S_SUB;
        end
        S_SUB: begin
          r_quo   <= r_q;
          r_rmd   <= r_rem;
          r_dif   <= w_diff;
          r_bor   <= w_borrow;
          r_dvz   <= r_dz;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
